// File: rtl/seg_scan_ctrl_if.sv
// Load-side bus between a data formatter (master) and seg_scan_ctrl (slave).
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    load;
  logic [8*NUM_DIGITS-1:0] chars;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    load_ack;

  modport master (output load, chars, dp_mask, blink_mask, input load_ack);
  modport slave  (input load, chars, dp_mask, blink_mask, output load_ack);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous shadow updates.
// Optional blinking is built only when SEG_BLINK_EN is defined.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int DIG_CYCLES   = 50_000,
  parameter int BLANK_CYCLES = 0,
  parameter int BLINK_FRAMES = 83
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_ctrl_if.slave        bus,
  input  logic                  lzb_en,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] sel,
  output logic                  frame_start
);
  localparam int CW = $clog2(DIG_CYCLES);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIG_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0][7:0] SPACES = {NUM_DIGITS{8'h20}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dig_q, dig_d;
  logic          wrap_s, in_blank_s;
  logic          pend_q, pend_d;
  logic [NUM_DIGITS-1:0][7:0] pnd_chars_q, pnd_chars_d, act_chars_q, act_chars_d;
  logic [NUM_DIGITS-1:0] pnd_dp_q, pnd_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] lzb_blank_s, blink_off_s;
  logic [7:0]            seg_q, seg_d, pat_s;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  frame_start_q, load_ack_q, load_ack_d, lead_s;

  function automatic logic [7:0] decode7(input logic [7:0] c);
    logic [7:0] p;
    case (c)
      8'h30: p = 8'hC0;  8'h31: p = 8'hF9;  8'h32: p = 8'hA4;  8'h33: p = 8'hB0;
      8'h34: p = 8'h99;  8'h35: p = 8'h92;  8'h36: p = 8'h82;  8'h37: p = 8'hF8;
      8'h38: p = 8'h80;  8'h39: p = 8'h90;
      8'h41: p = 8'h88;  8'h42: p = 8'h83;  8'h43: p = 8'hC6;  8'h44: p = 8'hA1;
      8'h45: p = 8'h86;  8'h46: p = 8'h8E;
      8'h2D: p = 8'hBF;
      default: p = 8'hFF;
    endcase
    return p;
  endfunction

  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign in_blank_s = (cnt_q < CW'(BLANK_CYCLES));
    end else begin : g_noblank
      assign in_blank_s = 1'b0;
    end
  endgenerate

  // Slot counter and digit index; wrap_s marks the frame boundary cycle.
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    dig_d  = dig_q;
    wrap_s = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (dig_q == DIG_LAST) begin
        dig_d  = '0;
        wrap_s = 1'b1;
      end else begin
        dig_d = dig_q + DW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Pending/active shadow registers; a load in the boundary cycle commits directly.
  always_comb begin
    pend_d      = pend_q;
    pnd_chars_d = pnd_chars_q;
    pnd_dp_d    = pnd_dp_q;
    act_chars_d = act_chars_q;
    act_dp_d    = act_dp_q;
    load_ack_d  = 1'b0;
    if (bus.load) begin
      pnd_chars_d = bus.chars;
      pnd_dp_d    = bus.dp_mask;
      pend_d      = 1'b1;
    end else begin
      pend_d = pend_q;
    end
    if (wrap_s && bus.load) begin
      act_chars_d = bus.chars;
      act_dp_d    = bus.dp_mask;
      pend_d      = 1'b0;
      load_ack_d  = 1'b1;
    end else if (wrap_s && pend_q) begin
      act_chars_d = pnd_chars_q;
      act_dp_d    = pnd_dp_q;
      pend_d      = 1'b0;
      load_ack_d  = 1'b1;
    end else begin
      load_ack_d = 1'b0;
    end
  end

  // Leading zeros blank from the leftmost digit down; digit 0 always shows.
  always_comb begin
    lead_s      = 1'b1;
    lzb_blank_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead_s         = lead_s & (act_chars_q[i] == 8'h30);
      lzb_blank_s[i] = lead_s & lzb_en;
    end
  end

  // Segment/select pattern for the current slot; DP survives blanking but not blinking.
  always_comb begin
    seg_d = 8'hFF;
    sel_d = '0;
    pat_s = 8'hFF;
    if (!in_blank_s) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        sel_d[i] = (dig_q == DW'(i));
      end
      pat_s    = lzb_blank_s[dig_q] ? 8'hFF : decode7(act_chars_q[dig_q]);
      pat_s[7] = ~act_dp_q[dig_q];
      seg_d    = blink_off_s[dig_q] ? 8'hFF : pat_s;
    end else begin
      seg_d = 8'hFF;
      sel_d = '0;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  logic [FW-1:0]         frm_q, frm_d;
  logic                  phase_q, phase_d;
  logic [NUM_DIGITS-1:0] pnd_blink_q, pnd_blink_d, act_blink_q, act_blink_d;

  // Frame counter toggles the blink phase; blink mask follows the same shadowing as chars.
  always_comb begin
    frm_d       = frm_q;
    phase_d     = phase_q;
    pnd_blink_d = bus.load ? bus.blink_mask : pnd_blink_q;
    act_blink_d = act_blink_q;
    if (wrap_s) begin
      frm_d       = (frm_q == FRM_LAST) ? '0 : frm_q + FW'(1);
      phase_d     = (frm_q == FRM_LAST) ? ~phase_q : phase_q;
      act_blink_d = bus.load ? bus.blink_mask : (pend_q ? pnd_blink_q : act_blink_q);
    end else begin
      frm_d = frm_q;
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_q       <= '0;
      phase_q     <= 1'b0;
      pnd_blink_q <= '0;
      act_blink_q <= '0;
    end else begin
      frm_q       <= frm_d;
      phase_q     <= phase_d;
      pnd_blink_q <= pnd_blink_d;
      act_blink_q <= act_blink_d;
    end
  end

  assign blink_off_s = phase_q ? act_blink_q : '0;
`else
  assign blink_off_s = '0;
`endif

  // Core state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      dig_q         <= '0;
      pend_q        <= 1'b0;
      pnd_chars_q   <= SPACES;
      act_chars_q   <= SPACES;
      pnd_dp_q      <= '0;
      act_dp_q      <= '0;
      seg_q         <= 8'hFF;
      sel_q         <= '0;
      frame_start_q <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dig_q         <= dig_d;
      pend_q        <= pend_d;
      pnd_chars_q   <= pnd_chars_d;
      act_chars_q   <= act_chars_d;
      pnd_dp_q      <= pnd_dp_d;
      act_dp_q      <= act_dp_d;
      seg_q         <= seg_d;
      sel_q         <= sel_d;
      frame_start_q <= wrap_s;
      load_ack_q    <= load_ack_d;
    end
  end

  assign seg          = seg_q;
  assign sel          = sel_q;
  assign frame_start  = frame_start_q;
  assign bus.load_ack = load_ack_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: arithmetic scan model compared every cycle,
// plus literal digit expectations; works with or without SEG_BLINK_EN.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  localparam int ND = 4;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = ND * DC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          lzb_en = 1'b0;
  logic [7:0]    seg;
  logic [ND-1:0] sel;
  logic          frame_start;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(.NUM_DIGITS(ND), .DIG_CYCLES(DC), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .lzb_en(lzb_en),
    .seg(seg), .sel(sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release.
  int unsigned ecount = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecount <= 0;
    else        ecount <= ecount + 1;
  end

  int checks = 0;
  int failures = 0;

  // Model state: what the display must hold, per the shadow-register rules.
  logic [7:0]    m_act [ND];
  logic [7:0]    m_pnd [ND];
  logic [ND-1:0] m_act_dp, m_pnd_dp, m_act_bl, m_pnd_bl;
  bit            m_pend;
  logic [7:0]    exp_seg;
  logic [ND-1:0] exp_sel;
  logic          exp_fs, exp_ack;

  // Literal expectation requests from the stimulus.
  string         pin_name = "";
  logic [ND-1:0] pin_sel = '0;
  logic [7:0]    pin_seg = 8'h00;
  int            pin_id = 0;
  int            pin_served = 0;
  int            pin_age = 0;

  function automatic logic [7:0] glyph(input logic [7:0] c);
    logic [7:0] dec [10];
    logic [7:0] hex [6];
    dec = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    hex = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    if (c >= 8'h30 && c <= 8'h39) return dec[c - 8'h30];
    if (c >= 8'h41 && c <= 8'h46) return hex[c - 8'h41];
    if (c == 8'h2D) return 8'hBF;
    return 8'hFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Outputs after the edge that closes cycle s (cycles counted from reset release).
  task automatic expect_at(input int unsigned s, output logic [7:0] es, output logic [ND-1:0] esel);
    int unsigned slot, d;
    bit zeros, phase;
    slot = s % DC;
    d    = (s / DC) % ND;
    es   = 8'hFF;
    esel = '0;
    if (slot >= BC) begin
      esel  = ND'(1) << d;
      zeros = (lzb_en == 1'b1) && (d != 0);
      for (int j = 0; j < ND; j++)
        if (j >= int'(d) && m_act[j] != 8'h30) zeros = 1'b0;
      es = zeros ? 8'hFF : glyph(m_act[d]);
      if (m_act_dp[d]) es[7] = 1'b0;
      phase = (((s / FRAME) / BF) % 2) == 1;
`ifdef SEG_BLINK_EN
      if (phase && m_act_bl[d]) es = 8'hFF;
`endif
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < ND; j++) begin
      m_act[j] = 8'h20;
      m_pnd[j] = 8'h20;
    end
    m_act_dp = '0; m_pnd_dp = '0; m_act_bl = '0; m_pnd_bl = '0;
    m_pend = 1'b0;
  endtask

  // Compare process: check last cycle's predictions, then predict the next edge.
  always @(negedge clk) begin
    int unsigned e;
    if (!rst_n) begin
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_frame_start", 32'(frame_start), 32'h0);
      chk("rst_load_ack", 32'(bus.load_ack), 32'h0);
      model_reset();
      expect_at(0, exp_seg, exp_sel);
      exp_fs  = 1'b0;
      exp_ack = 1'b0;
    end else begin
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("sel", 32'(sel), 32'(exp_sel));
      chk("frame_start", 32'(frame_start), 32'(exp_fs));
      chk("load_ack", 32'(bus.load_ack), 32'(exp_ack));
      if (pin_id != pin_served) begin
        if (sel == pin_sel) begin
          chk(pin_name, 32'(seg), 32'(pin_seg));
          pin_served = pin_id;
          pin_age = 0;
        end else if (pin_age > 200) begin
          chk({pin_name, "_timeout"}, 32'(sel), 32'(pin_sel));
          pin_served = pin_id;
          pin_age = 0;
        end else begin
          pin_age++;
        end
      end
      expect_at(ecount, exp_seg, exp_sel);
      e       = ecount + 1;
      exp_fs  = (e % FRAME) == 0;
      exp_ack = 1'b0;
      if (bus.load) begin
        for (int j = 0; j < ND; j++) m_pnd[j] = bus.chars[8*j +: 8];
        m_pnd_dp = bus.dp_mask;
        m_pnd_bl = bus.blink_mask;
        m_pend   = 1'b1;
      end
      if (exp_fs && m_pend) begin
        for (int j = 0; j < ND; j++) m_act[j] = m_pnd[j];
        m_act_dp = m_pnd_dp;
        m_act_bl = m_pnd_bl;
        m_pend   = 1'b0;
        exp_ack  = 1'b1;
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic do_load(input logic [31:0] c, input logic [ND-1:0] dp, input logic [ND-1:0] bl);
    bus.load = 1'b1; bus.chars = c; bus.dp_mask = dp; bus.blink_mask = bl;
    @(posedge clk); #1;
    bus.load = 1'b0;
  endtask

  task automatic wait_mod(input int unsigned r);
    for (int i = 0; i < 100 && (ecount % FRAME) != r; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_until(input int unsigned n);
    for (int i = 0; i < 2000 && ecount < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pin(input string nm, input logic [ND-1:0] s, input logic [7:0] v);
    pin_name = nm; pin_sel = s; pin_seg = v;
    pin_id++;
    for (int i = 0; i < 400 && pin_served != pin_id; i++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rnd_char();
    case ($urandom_range(0, 5))
      0, 1:    return 8'h30;
      2:       return 8'(8'h31 + $urandom_range(0, 8));
      3:       return 8'(8'h41 + $urandom_range(0, 5));
      4:       return 8'h2D;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [31:0] rc;
    bus.load = 1'b0; bus.chars = {ND{8'h20}}; bus.dp_mask = '0; bus.blink_mask = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    pin("idle_d0", 4'b0001, 8'hFF);

    wait_mod(12);
    do_load("1234", 4'b0100, 4'b0000);
    wait_mod(1);
    pin("n1234_d0", 4'b0001, 8'h99);
    pin("n1234_d1", 4'b0010, 8'hB0);
    pin("n1234_d2", 4'b0100, 8'h24);
    pin("n1234_d3", 4'b1000, 8'hF9);

    lzb_en = 1'b1;
    do_load("0005", 4'b0000, 4'b0000);
    wait_mod(1);
    pin("lzb0005_d0", 4'b0001, 8'h92);
    pin("lzb0005_d1", 4'b0010, 8'hFF);
    pin("lzb0005_d3", 4'b1000, 8'hFF);
    do_load("0000", 4'b0000, 4'b0000);
    wait_mod(1);
    pin("lzb0000_d0", 4'b0001, 8'hC0);
    pin("lzb0000_d1", 4'b0010, 8'hFF);
    do_load("0-05", 4'b0000, 4'b0000);
    wait_mod(1);
    pin("lzb0m05_d1", 4'b0010, 8'hC0);
    pin("lzb0m05_d2", 4'b0100, 8'hBF);
    pin("lzb0m05_d3", 4'b1000, 8'hFF);
    lzb_en = 1'b0;

    do_load("ZA- ", 4'b0000, 4'b0000);
    wait_mod(1);
    pin("misc_d0", 4'b0001, 8'hFF);
    pin("misc_d1", 4'b0010, 8'hBF);
    pin("misc_d2", 4'b0100, 8'h88);
    pin("misc_d3", 4'b1000, 8'hFF);
    wait_mod(8);
    do_load("9999", 4'b0000, 4'b0000);
    wait_mod(20);
    do_load("7777", 4'b0000, 4'b0000);
    wait_mod(1);
    pin("lastwins_d0", 4'b0001, 8'hF8);

    pulse_reset(2);
    do_load("8888", 4'b0000, 4'b0001);
    wait_until(65);
`ifdef SEG_BLINK_EN
    pin("blink_f2_d0", 4'b0001, 8'hFF);
`else
    pin("blink_f2_d0", 4'b0001, 8'h80);
`endif
    pin("blink_f2_d1", 4'b0010, 8'h80);
    wait_until(129);
    pin("blink_f4_d0", 4'b0001, 8'h80);

    do_load("1234", 4'b0100, 4'b0000);
    wait_mod(1);
    wait_mod(18);
    do_load("5678", 4'b1111, 4'b0000);
    pulse_reset(3);
    pin("postrst_d2", 4'b0100, 8'hFF);
    repeat (2 * FRAME) @(posedge clk);
    #1;

    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 45)) @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 40 && ((ecount + 1) % FRAME) != 0; i++) begin
          @(posedge clk); #1;
        end
      end
      if ($urandom_range(0, 2) == 0) lzb_en = 1'($urandom_range(0, 1));
      rc = {rnd_char(), rnd_char(), rnd_char(), rnd_char()};
      do_load(rc, ND'($urandom_range(0, 15)), ND'($urandom_range(0, 15)));
    end
    repeat (3 * FRAME) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised time-multiplexed 7-segment scan controller for the board's common-anode display bank. It supersedes the fixed six-digit HH:MM:SS scanner and takes packed ASCII characters for any digit count. It adds per-digit decimal points, frame-synchronous (tear-free) updates, leading-zero blanking, an anti-ghosting blank interval and optional blinking. It sits between the data formatters (GPS time, UART readouts) and the HC595 shift-register driver.

## Interface
- NUM_DIGITS, 6: number of digits scanned; legal range 2..8.
- DIG_CYCLES, 50_000: clocks per digit slot; minimum BLANK_CYCLES+2.
- BLANK_CYCLES, 0: clocks at slot start with all segments and selects off.
- BLINK_FRAMES, 83: frames per blink half-period; minimum 1.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  single-cycle strobe that captures chars/dp_mask/blink_mask.
- chars  in  8*NUM_DIGITS  ASCII; digit i = bits [8i+7:8i]; digit 0 is rightmost.
- dp_mask  in  NUM_DIGITS  bit i lights the DP of digit i.
- blink_mask  in  NUM_DIGITS  bit i makes digit i blink.
- lzb_en  in  1  leading-zero blanking enable (live, not shadowed).
- seg  out  8  segment pattern, active-low; bit7 = DP, bits 6:0 = g..a.
- sel  out  NUM_DIGITS  one-hot digit select, active-high.
- frame_start  out  1  one-cycle pulse at each frame boundary.
- load_ack  out  1  one-cycle pulse when pending data is committed.

## Operation
- Slot counter counts 0..DIG_CYCLES-1 and wraps. The digit index advances on wrap and runs 0..NUM_DIGITS-1, returning to 0 after the last digit.
- Frame boundary: the cycle in which the digit index wraps to 0.
- Shadow registers:
  - `load` copies its inputs into the pending registers and sets `pend`. A repeated `load` overwrites the pending data; the last one wins.
  - At a frame boundary with `pend`=1, active <= pending, `pend` clears and `load_ack` pulses.
  - If `load` coincides with the boundary, the load data commits directly and `load_ack` pulses.
- Decode, per active character:
  - '0'..'9' → C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - 'A'..'F' → 88, 83, C6, A1, 86, 8E.
  - '-' → BF.
  - Any other code, including ' ', → FF.
- DP: `dp_mask[i]`=1 forces seg[7]=0 for digit i. This applies even when the digit is blanked.
- Leading-zero blanking (`lzb_en`=1):
  - Scan from digit NUM_DIGITS-1 downward; each '0' reads as FF until the first non-'0' character.
  - Digit 0 is never blanked.
- Blank interval: while slot counter < BLANK_CYCLES, sel=0 and seg=FF.
- Reset values:
  - seg=FF, sel=0, frame_start=0, load_ack=0.
  - Active and pending chars = ' '; dp, blink and `pend` = 0.
  - Slot counter, digit index and blink state = 0.
- Reset mid-operation: every output takes its reset value immediately and any pending load is discarded.

## Timing
- seg and sel are registered and lag the slot counter and digit index by one clock.
- Each digit is selected for DIG_CYCLES-BLANK_CYCLES clocks per frame.
- Frame period = NUM_DIGITS*DIG_CYCLES clocks.
- frame_start and load_ack assert in the boundary cycle, one clock before sel reflects digit 0 with the new data.
- Data change to visible segments: at most one frame plus one clock after `load`.
- No arithmetic overflow: counter widths are $clog2 of each maximum, and the counters wrap explicitly.

## Configuration
- SEG_BLINK_EN defined:
  - A frame counter counts 0..BLINK_FRAMES-1 and toggles the blink phase on wrap.
  - While the phase is 1, digits with active blink bit=1 drive seg=FF including DP; sel still asserts.
  - The phase resets to 0.
- SEG_BLINK_EN undefined: no blink counter is built, `blink_mask` is ignored, and digits are never blinked.

## Test plan
Parameters for the bench: NUM_DIGITS=4, DIG_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2.

1. Reset release, no load → sel=0 and seg=FF until the third rising edge, then sel=0001 for 6 clocks, sel=0 for 2 clocks, then 0010; the 32-clock frame repeats. frame_start pulses every 32 clocks.
2. `load` at mid-frame with chars="1234" (digit0='4') and dp_mask=0100 → seg unchanged until frame_start. load_ack pulses in the same cycle. Next frame: digit0=99, digit1=B0, digit2=24, digit3=F9.
3. `lzb_en`=1 with "0005" → digits 3..1 = FF, digit0=92. With "0000" → only digit0 = C0. With "0-05" → digit3=FF, digit2=BF, digit1=C0.
4. Characters "Z", "A", "-", " " → FF, 88, BF, FF. A second `load` before the boundary → only the second value is displayed and load_ack pulses once.
5. SEG_BLINK_EN defined, blink_mask=0001, chars="8888" → digit0 reads 80 in frames 0–1, FF in frames 2–3, 80 again in frames 4–5. Other digits read 80 throughout. With the macro undefined, digit0 reads 80 always.
6. rst_n low during digit2's slot with a load pending → sel=0 and seg=FF asynchronously. After release the display is blank and no load_ack pulse occurs.
